ir_code_lock: RTL

Four-digit passcode lock driven by the NEC IR remote. Sits directly downstream of the IR receiver. It consumes the receiver's 32-bit decoded frame and data-ready flag, validates each frame and classifies the key. It maintains a 4-digit entry register for the HEX displays and runs the unlock / fail / lockout state machine driving the status LEDs.

---
 rtl/ir_lock_pkg.sv | 37 +++
 rtl/nec_frame_filter.sv | 50 +++++
 rtl/ir_code_lock.sv | 112 +++++++++++
 3 files changed

// File: rtl/ir_lock_pkg.sv
// Shared types and NEC frame field positions for the IR passcode lock.
package ir_lock_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY,
    ST_CHECK,
    ST_OPEN,
    ST_FAIL,
    ST_LOCKOUT
  } state_e;

  typedef enum logic [1:0] {
    K_NONE,
    K_DIGIT,
    K_ENTER,
    K_CLEAR
  } key_class_e;

  localparam int unsigned NEC_INV_MSB  = 31;
  localparam int unsigned NEC_INV_LSB  = 24;
  localparam int unsigned NEC_KEY_MSB  = 23;
  localparam int unsigned NEC_KEY_LSB  = 16;
  localparam int unsigned NEC_CUST_MSB = 15;
  localparam int unsigned NEC_CUST_LSB = 0;

  localparam logic [7:0] KEY_DIGIT_MAX = 8'h09;

  function automatic key_class_e classify_key(input logic [7:0] key,
                                              input logic [7:0] enter_code,
                                              input logic [7:0] clear_code);
    if (key <= KEY_DIGIT_MAX)   return K_DIGIT;
    else if (key == enter_code) return K_ENTER;
    else if (key == clear_code) return K_CLEAR;
    else                        return K_NONE;
  endfunction

endpackage

// File: rtl/nec_frame_filter.sv
// Turns the receiver's level-valid frame into a one-cycle classified key event.
module nec_frame_filter
  import ir_lock_pkg::*;
#(
  parameter logic [15:0] CUSTOM_CODE = 16'h6B86,
  parameter logic [7:0]  KEY_ENTER   = 8'h16,
  parameter logic [7:0]  KEY_CLEAR   = 8'h0C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_ready,
  input  logic [31:0] data,
  output logic        ev,
  output key_class_e  ev_class,
  output logic [3:0]  ev_digit
);

  logic       ready_d;
  logic [7:0] key;
  logic [7:0] key_inv;
  logic [15:0] cust;
  key_class_e cls_c;
  logic       accept;

  assign key     = data[NEC_KEY_MSB:NEC_KEY_LSB];
  assign key_inv = data[NEC_INV_MSB:NEC_INV_LSB];
  assign cust    = data[NEC_CUST_MSB:NEC_CUST_LSB];

  always_comb begin
    cls_c  = classify_key(key, KEY_ENTER, KEY_CLEAR);
    accept = data_ready && !ready_d && (key_inv == ~key) &&
             (cust == CUSTOM_CODE) && (cls_c != K_NONE);
  end

  // ready_d resets high so a level already present at reset release is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_d  <= 1'b1;
      ev       <= 1'b0;
      ev_class <= K_NONE;
      ev_digit <= '0;
    end else begin
      ready_d  <= data_ready;
      ev       <= accept;
      ev_class <= accept ? cls_c : K_NONE;
      ev_digit <= key[3:0];
    end
  end

endmodule

// File: rtl/ir_code_lock.sv
// Four-digit IR passcode lock: entry register, unlock/fail/lockout FSM, shared timer.
module ir_code_lock
  import ir_lock_pkg::*;
#(
  parameter logic [15:0] PASSCODE    = 16'h1234,
  parameter logic [15:0] CUSTOM_CODE = 16'h6B86,
  parameter logic [7:0]  KEY_ENTER   = 8'h16,
  parameter logic [7:0]  KEY_CLEAR   = 8'h0C,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned OPEN_CYCLES = 150_000_000,
  parameter int unsigned LOCK_CYCLES = 500_000_000
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iDATA_READY,
  input  logic [31:0] iDATA,
  output logic [15:0] oENTRY,
  output logic [2:0]  oCOUNT,
  output logic        oUNLOCK,
  output logic        oFAIL,
  output logic        oLOCKOUT,
  output logic [1:0]  oFAIL_CNT
);

  localparam logic [1:0]  MAX_FAIL_W = 2'(MAX_FAIL);
  localparam logic [31:0] OPEN_LOAD  = 32'(OPEN_CYCLES - 1);
  localparam logic [31:0] LOCK_LOAD  = 32'(LOCK_CYCLES - 1);

  logic       ev;
  key_class_e ev_class;
  logic [3:0] ev_digit;

  state_e      state, state_nxt;
  logic [31:0] timer;
  logic        pass_c;

  nec_frame_filter #(
    .CUSTOM_CODE(CUSTOM_CODE),
    .KEY_ENTER  (KEY_ENTER),
    .KEY_CLEAR  (KEY_CLEAR)
  ) u_filter (
    .clk       (iCLK),
    .rst_n     (iRST_n),
    .data_ready(iDATA_READY),
    .data      (iDATA),
    .ev        (ev),
    .ev_class  (ev_class),
    .ev_digit  (ev_digit)
  );

  always_comb begin
    state_nxt = state;
    pass_c    = (oCOUNT == 3'd4) && (oENTRY == PASSCODE);
    case (state)
      ST_ENTRY:   if (ev && ev_class == K_ENTER) state_nxt = ST_CHECK;
      ST_CHECK:   state_nxt = pass_c ? ST_OPEN : ST_FAIL;
      ST_OPEN:    if (timer == '0) state_nxt = ST_ENTRY;
      ST_FAIL:    state_nxt = (oFAIL_CNT == MAX_FAIL_W) ? ST_LOCKOUT : ST_ENTRY;
      ST_LOCKOUT: if (timer == '0) state_nxt = ST_ENTRY;
      default:    state_nxt = ST_ENTRY;
    endcase
  end

  // Status outputs follow the next state so they line up with the state register.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state     <= ST_ENTRY;
      timer     <= '0;
      oENTRY    <= '0;
      oCOUNT    <= '0;
      oUNLOCK   <= 1'b0;
      oFAIL     <= 1'b0;
      oLOCKOUT  <= 1'b0;
      oFAIL_CNT <= '0;
    end else begin
      state    <= state_nxt;
      oUNLOCK  <= (state_nxt == ST_OPEN);
      oFAIL    <= (state_nxt == ST_FAIL);
      oLOCKOUT <= (state_nxt == ST_LOCKOUT);

      if (state == ST_CHECK && state_nxt == ST_OPEN)
        timer <= OPEN_LOAD;
      else if (state == ST_FAIL && state_nxt == ST_LOCKOUT)
        timer <= LOCK_LOAD;
      else if (timer != '0)
        timer <= timer - 32'd1;

      if (state == ST_ENTRY && ev) begin
        case (ev_class)
          K_DIGIT: begin
            oENTRY <= {oENTRY[11:0], ev_digit};
            if (oCOUNT != 3'd4) oCOUNT <= oCOUNT + 3'd1;
          end
          K_CLEAR: begin
            oENTRY <= '0;
            oCOUNT <= '0;
          end
          default: ;
        endcase
      end else if (state == ST_CHECK) begin
        oENTRY <= '0;
        oCOUNT <= '0;
      end

      if (state == ST_CHECK)
        oFAIL_CNT <= pass_c ? 2'd0 : oFAIL_CNT + 2'd1;
      else if (state == ST_LOCKOUT && timer == '0)
        oFAIL_CNT <= '0;
    end
  end

endmodule
